// File: rtl/pkt_rx_pkt_buf_if.sv
// Bundle of MAC-side write port and user-side pkt_rx read port for the receive packet buffer.
interface pkt_rx_pkt_buf_if #(
  parameter int DATA_W = 64
);
  localparam int MOD_W = $clog2(DATA_W / 8);

  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [MOD_W-1:0]  in_mod;
  logic              in_val;
  logic              in_full;
  logic              pkt_rx_avail;
  logic              pkt_rx_ren;
  logic [DATA_W-1:0] pkt_rx_data;
  logic              pkt_rx_sop;
  logic              pkt_rx_eop;
  logic [MOD_W-1:0]  pkt_rx_mod;
  logic              pkt_rx_val;
  logic [15:0]       drop_cnt;
  logic [15:0]       malformed_cnt;

  modport master (
    output in_data, in_sop, in_eop, in_mod, in_val, pkt_rx_ren,
    input  in_full, pkt_rx_avail, pkt_rx_data, pkt_rx_sop, pkt_rx_eop,
           pkt_rx_mod, pkt_rx_val, drop_cnt, malformed_cnt
  );

  modport slave (
    input  in_data, in_sop, in_eop, in_mod, in_val, pkt_rx_ren,
    output in_full, pkt_rx_avail, pkt_rx_data, pkt_rx_sop, pkt_rx_eop,
           pkt_rx_mod, pkt_rx_val, drop_cnt, malformed_cnt
  );
endinterface

// File: rtl/pkt_rx_pkt_buf.sv
// Store-and-forward receive packet buffer: only committed whole packets become readable.
// Define PKT_RX_PKT_BUF_STATS_EN to enable the saturating drop/malformed counters.
module pkt_rx_pkt_buf #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 512,
  parameter int FULL_MARGIN = 4
) (
  input logic             clk_156m25,
  input logic             reset_156m25,
  pkt_rx_pkt_buf_if.slave bus
);
  localparam int MOD_W  = $clog2(DATA_W / 8);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int WORD_W = DATA_W + MOD_W + 2;
  localparam logic [PTR_W-1:0] DEPTH_P  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] MARGIN_P = PTR_W'(FULL_MARGIN);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [WORD_W-1:0] mem [DEPTH];

  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [PTR_W-1:0]  base;
  logic [MOD_W-1:0]  wr_mod;
  logic [WORD_W-1:0] wr_word;
  logic              start, body;
  logic              commit_inc, mal_inc, drop_inc;

  logic              rd_en, eop_rd;
  logic [WORD_W-1:0] rd_word;

  logic              rx_val_q, rx_val_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_sop_q, rx_sop_d;
  logic              rx_eop_q, rx_eop_d;
  logic [MOD_W-1:0]  rx_mod_q, rx_mod_d;
  logic              avail_q, avail_d;
  logic              in_full_q, in_full_d;

  // Write FSM: a sop inside RECV rewinds to the last commit before restarting,
  // so the full test must be made against the rewound pointer.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;
    base         = wr_ptr_q;
    start        = 1'b0;
    body         = 1'b0;
    commit_inc   = 1'b0;
    mal_inc      = 1'b0;
    drop_inc     = 1'b0;
    wr_mod       = bus.in_eop ? bus.in_mod : {MOD_W{1'b0}};
    wr_word      = {bus.in_sop, bus.in_eop, wr_mod, bus.in_data};
    if (bus.in_val) begin
      case (state_q)
        IDLE: begin
          start   = bus.in_sop;
          mal_inc = !bus.in_sop;
        end
        RECV: begin
          if (bus.in_sop) begin
            base    = commit_ptr_q;
            mal_inc = 1'b1;
            start   = 1'b1;
          end else begin
            body = 1'b1;
          end
        end
        default: begin
          if (bus.in_sop)      start   = 1'b1;
          else if (bus.in_eop) state_d = IDLE;
        end
      endcase
      wr_ptr_d = base;
      if (start || body) begin
        if ((base - rd_ptr_q) == DEPTH_P) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          state_d  = bus.in_eop ? IDLE : DROP;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = base;
          wr_ptr_d = base + 1'b1;
          if (bus.in_eop) begin
            commit_ptr_d = base + 1'b1;
            commit_inc   = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = RECV;
          end
        end
      end
    end
  end

  assign rd_en   = bus.pkt_rx_ren && (rd_ptr_q != commit_ptr_q);
  assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
  assign eop_rd  = rd_en && rd_word[WORD_W-2];

  always_comb begin
    rd_ptr_d  = rd_ptr_q + PTR_W'(rd_en);
    pkt_cnt_d = pkt_cnt_q;
    if (commit_inc && !eop_rd)      pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (!commit_inc && eop_rd) pkt_cnt_d = pkt_cnt_q - 1'b1;
    rx_val_d  = rd_en;
    rx_data_d = rx_data_q;
    rx_sop_d  = 1'b0;
    rx_eop_d  = 1'b0;
    rx_mod_d  = {MOD_W{1'b0}};
    if (rd_en) begin
      rx_data_d = rd_word[DATA_W-1:0];
      rx_sop_d  = rd_word[WORD_W-1];
      rx_eop_d  = rd_word[WORD_W-2];
      rx_mod_d  = rd_word[DATA_W +: MOD_W];
    end
    avail_d   = (pkt_cnt_q != '0);
    in_full_d = (DEPTH_P - (wr_ptr_q - rd_ptr_q)) <= MARGIN_P;
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_cnt_q    <= '0;
      rx_val_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_sop_q     <= 1'b0;
      rx_eop_q     <= 1'b0;
      rx_mod_q     <= '0;
      avail_q      <= 1'b0;
      in_full_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      rx_val_q     <= rx_val_d;
      rx_data_q    <= rx_data_d;
      rx_sop_q     <= rx_sop_d;
      rx_eop_q     <= rx_eop_d;
      rx_mod_q     <= rx_mod_d;
      avail_q      <= avail_d;
      in_full_q    <= in_full_d;
    end
  end

  // Storage array carries no reset; stale words are unreachable behind the pointers.
  always_ff @(posedge clk_156m25) begin
    if (wr_en) mem[wr_addr[ADDR_W-1:0]] <= wr_word;
  end

  assign bus.in_full      = in_full_q;
  assign bus.pkt_rx_avail = avail_q;
  assign bus.pkt_rx_val   = rx_val_q;
  assign bus.pkt_rx_data  = rx_data_q;
  assign bus.pkt_rx_sop   = rx_sop_q;
  assign bus.pkt_rx_eop   = rx_eop_q;
  assign bus.pkt_rx_mod   = rx_mod_q;

`ifdef PKT_RX_PKT_BUF_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] mal_cnt_q, mal_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_comb begin
    drop_cnt_d = sat_inc(drop_cnt_q, drop_inc);
    mal_cnt_d  = sat_inc(mal_cnt_q, mal_inc);
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      drop_cnt_q <= '0;
      mal_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      mal_cnt_q  <= mal_cnt_d;
    end
  end

  assign bus.drop_cnt      = drop_cnt_q;
  assign bus.malformed_cnt = mal_cnt_q;
`else
  logic unused_stats;
  assign unused_stats      = drop_inc ^ mal_inc;
  assign bus.drop_cnt      = 16'd0;
  assign bus.malformed_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pkt_rx_pkt_buf.sv
// Scoreboard bench for pkt_rx_pkt_buf with DEPTH=16, FULL_MARGIN=4, DATA_W=64.
module tb_pkt_rx_pkt_buf;
  localparam int DATA_W = 64;
  localparam int MOD_W  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W+MOD_W+1:0] sb [$];
  logic [15:0] exp_drop, exp_mal;

  always #5 clk = ~clk;

  pkt_rx_pkt_buf_if #(.DATA_W(DATA_W)) bus ();

  pkt_rx_pkt_buf #(.DATA_W(DATA_W), .DEPTH(16), .FULL_MARGIN(4)) dut (
    .clk_156m25  (clk),
    .reset_156m25(rst),
    .bus         (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Every valid read word must match the oldest expected word.
  always @(negedge clk) begin : mon
    logic [DATA_W+MOD_W+1:0] e;
    if (!rst && bus.pkt_rx_val) begin
      if (sb.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rd_word", {bus.pkt_rx_sop, bus.pkt_rx_eop, bus.pkt_rx_mod, bus.pkt_rx_data}, e);
      end
    end
  end

  task automatic wr(input logic sop, input logic eop, input logic [MOD_W-1:0] mod,
                    input logic [DATA_W-1:0] d, input bit keep);
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_sop  = sop;
    bus.in_eop  = eop;
    bus.in_mod  = mod;
    bus.in_data = d;
    if (keep) sb.push_back({sop, eop, eop ? mod : 3'd0, d});
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_val = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.in_mod = '0;
  endtask

  task automatic send_pkt(input int n, input logic [MOD_W-1:0] mod, input bit keep);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      wr(i == 0, i == n - 1, (i == n - 1) ? mod : 3'd0, d, keep);
    end
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.pkt_rx_ren = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    bus.pkt_rx_ren = 1'b0;
    check("drain_done", sb.size() == 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
`ifdef PKT_RX_PKT_BUF_STATS_EN
    exp_drop = 16'd1;
    exp_mal  = 16'd1;
`else
    exp_drop = 16'd0;
    exp_mal  = 16'd0;
`endif
    bus.in_val     = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_mod     = '0;
    bus.in_data    = '0;
    bus.pkt_rx_ren = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_val", bus.pkt_rx_val, 0);
    check("rst_avail", bus.pkt_rx_avail, 0);
    check("rst_full", bus.in_full, 0);
    check("rst_data", bus.pkt_rx_data, 0);
    check("rst_drop", bus.drop_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 3-word packet, mod=5, ren held 4 cycles
    send_pkt(3, 3'd5, 1'b1);
    check("t1_avail_early", bus.pkt_rx_avail, 0);
    @(negedge clk);
    check("t1_avail", bus.pkt_rx_avail, 1);
    bus.pkt_rx_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_val", bus.pkt_rx_val, i < 3);
    end
    bus.pkt_rx_ren = 1'b0;
    @(negedge clk);
    check("t1_avail_clr", bus.pkt_rx_avail, 0);
    check("t1_sb_empty", sb.size(), 0);

    // single-word packet
    send_pkt(1, 3'd0, 1'b1);
    @(negedge clk);
    check("t2_avail", bus.pkt_rx_avail, 1);
    drain();
    check("t2_avail_clr", bus.pkt_rx_avail, 0);

    // oversize packet dropped at word 17, then a good 2-word packet
    send_pkt(20, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("t3_avail", bus.pkt_rx_avail, 0);
    check("t3_full_clr", bus.in_full, 0);
    check("t3_drop", bus.drop_cnt, exp_drop);
    send_pkt(2, 3'd3, 1'b1);
    drain();

    // truncated fragment followed by a new packet
    wr(1'b1, 1'b0, 3'd0, 64'hAAAA_0000_0000_0001, 1'b0);
    wr(1'b0, 1'b0, 3'd0, 64'hAAAA_0000_0000_0002, 1'b0);
    wr(1'b1, 1'b0, 3'd0, 64'hBBBB_0000_0000_0003, 1'b1);
    wr(1'b0, 1'b1, 3'd2, 64'hBBBB_0000_0000_0004, 1'b1);
    idle();
    check("t4_mal", bus.malformed_cnt, exp_mal);
    drain();

    // fill to 12 words -> in_full, read one word -> clears
    send_pkt(4, 3'd1, 1'b1);
    send_pkt(4, 3'd2, 1'b1);
    send_pkt(4, 3'd3, 1'b1);
    check("t5_full_pre", bus.in_full, 0);
    @(negedge clk);
    check("t5_full", bus.in_full, 1);
    bus.pkt_rx_ren = 1'b1;
    @(negedge clk);
    bus.pkt_rx_ren = 1'b0;
    check("t5_full_hold", bus.in_full, 1);
    @(negedge clk);
    check("t5_full_rel", bus.in_full, 0);
    drain();

    // reset mid-read and mid-write
    send_pkt(4, 3'd6, 1'b1);
    @(negedge clk);
    bus.pkt_rx_ren = 1'b1;
    @(negedge clk);
    bus.in_val  = 1'b1;
    bus.in_sop  = 1'b1;
    bus.in_data = 64'hDEAD;
    @(negedge clk);
    bus.in_sop = 1'b0;
    #2;
    rst            = 1'b1;
    bus.in_val     = 1'b0;
    bus.pkt_rx_ren = 1'b0;
    sb.delete();
    #1;
    check("t6_val", bus.pkt_rx_val, 0);
    check("t6_data", bus.pkt_rx_data, 0);
    check("t6_sop", bus.pkt_rx_sop, 0);
    check("t6_avail", bus.pkt_rx_avail, 0);
    check("t6_drop", bus.drop_cnt, 0);
    check("t6_mal", bus.malformed_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_avail_post", bus.pkt_rx_avail, 0);
    check("t6_val_post", bus.pkt_rx_val, 0);
    send_pkt(2, 3'd7, 1'b1);
    @(negedge clk);
    check("t6_avail_new", bus.pkt_rx_avail, 1);
    drain();
    check("t6_avail_end", bus.pkt_rx_avail, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_rx_pkt_buf.md
Name: pkt_rx_pkt_buf

Overview:
Parametrised store-and-forward receive packet buffer between the MAC RX datapath and the user-side pkt_rx interface. It generalises the fixed 64-bit pkt_rx port to DATA_W/DEPTH and presents only complete packets to the user. Malformed and overflowing packets are dropped whole. It keeps the pkt_rx_avail/pkt_rx_ren/pkt_rx_val read protocol with 1-cycle read latency.

Parameters:
DATA_W, 64, data bus width in bits; multiple of 8; 32..256.
DEPTH, 512, buffer words; power of 2; ADDR_W = clog2(DEPTH).
FULL_MARGIN, 4, in_full asserts when free words <= FULL_MARGIN.
MOD_W (localparam), clog2(DATA_W/8), width of the byte-count field.

Ports:
clk_156m25  input  1  single clock domain
reset_156m25  input  1  asynchronous, active-high reset
in_data  input  DATA_W  write data from MAC RX
in_sop  input  1  start of packet, qualified by in_val
in_eop  input  1  end of packet, qualified by in_val
in_mod  input  MOD_W  valid bytes on the eop word; 0 means all bytes valid
in_val  input  1  write strobe
in_full  output  1  almost-full back-pressure to MAC
pkt_rx_avail  output  1  at least one complete packet is stored
pkt_rx_ren  input  1  user read request
pkt_rx_data  output  DATA_W  read data
pkt_rx_sop  output  1  start of packet on read data
pkt_rx_eop  output  1  end of packet on read data
pkt_rx_mod  output  MOD_W  byte count on the eop word
pkt_rx_val  output  1  read data valid
drop_cnt  output  16  dropped packets (optional feature)
malformed_cnt  output  16  malformed packets (optional feature)

Behaviour:
- Reset (async, any time): wr_ptr, commit_ptr and rd_ptr = 0; pkt_cnt = 0; write FSM = IDLE; all outputs 0. A packet partially written at reset is lost.
- Pointers are ADDR_W+1 bits and wrap naturally.
  - used = wr_ptr - rd_ptr.
  - Buffer is full when used == DEPTH.
  - Each stored word = {sop, eop, mod, data}.
- in_full is registered: 1 when (DEPTH - used) <= FULL_MARGIN.
- Write FSM states: IDLE, RECV, DROP. Only in_val cycles are evaluated.
  - IDLE:
    - sop=1 -> write word. If eop=1 also, commit and stay IDLE; else go to RECV.
    - sop=0 -> discard the word, malformed++, stay IDLE.
  - RECV:
    - sop=0, eop=0 -> write word.
    - eop=1 -> write word, commit (commit_ptr <= wr_ptr+1, pkt_cnt++), go to IDLE.
    - sop=1 -> rewind wr_ptr to commit_ptr, malformed++, then treat this word as a new packet start (IDLE rules, same cycle).
  - Any state, write attempted while full -> rewind wr_ptr to commit_ptr, drop_cnt++.
    - If the word has eop -> go to IDLE; else go to DROP.
  - DROP: discard words until an eop word, then go to IDLE. A sop word in DROP ends the drop and restarts as a new packet.
- Read side:
  - pkt_rx_avail = registered (pkt_cnt != 0).
  - A read occurs on a pkt_rx_ren cycle when rd_ptr != commit_ptr. In that case pkt_rx_data/sop/eop/mod are registered and pkt_rx_val=1 on the next cycle; rd_ptr++.
  - ren when rd_ptr == commit_ptr -> ignored; pkt_rx_val=0 on the next cycle.
  - Reading the eop word decrements pkt_cnt.
  - Same-cycle commit and eop-read -> pkt_cnt unchanged.
  - ren may stay high across packets; back-to-back packets stream without a gap.
  - pkt_rx_mod is only meaningful when pkt_rx_eop=1; otherwise it is 0.
- Uncommitted words are never readable, so the user sees only whole packets.
- Counters saturate at 0xFFFF.

Optional Feature:
PKT_RX_PKT_BUF_STATS_EN
- Defined: drop_cnt and malformed_cnt count as specified and saturate; both clear only on reset.
- Undefined: counter logic is removed; both ports are driven constant 0. All other behaviour is identical.

Test Plan:
- 3-word packet (sop, -, eop, mod=5) written, then ren held for 4 cycles -> pkt_rx_avail=1 two cycles after the eop write. pkt_rx_val=1 for 3 cycles starting 1 cycle after ren; sop on word 0, eop+mod=5 on word 2, val=0 on cycle 4. avail returns to 0.
- Single-word packet (sop=eop=1, mod=0) -> committed immediately, pkt_cnt=1, read back with sop=eop=1, mod=0.
- DEPTH=16, 20-word packet -> dropped at word 17. drop_cnt=1, pkt_rx_avail stays 0, used returns to 0. A following 2-word packet reads back correctly.
- sop, data, sop, eop sequence -> first fragment discarded, malformed_cnt=1. Only a 2-word packet is readable.
- Fill to DEPTH-FULL_MARGIN words -> in_full=1. Read 1 word -> in_full=0 one cycle later.
- Reset asserted mid-packet during a read -> all outputs 0 immediately. After release, avail=0 and a new packet streams correctly.
